// File: rtl/pll_sup_pkg.sv
// Shared state encoding and default timing for the TX PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT,
        ST_STABLE,
        ST_RUN,
        ST_RETRY,
        ST_FAULT
    } sup_state_t;

    localparam int unsigned DEF_RST_CYCLES    = 64;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 32000;
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_MAX_RETRIES   = 3;
    localparam int unsigned DEF_SYNC_STAGES   = 2;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchroniser for the asynchronous PLL LOCK indication.
module lock_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) chain <= '0;
        else     chain <= {chain[SYNC_STAGES-2:0], async_in};
    end

    assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// TX PLL bring-up supervisor: reset pulse, lock wait, stability qualification,
// retry and reference fail-over, sticky fault.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter bit          ALT_REF_EN    = 1'b1,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic       CLKI,
    input  logic       RST,
    input  logic       PLL_LOCK,
    output logic       PLL_RST,
    output logic       PLL_SEL,
    output logic       SYS_RST,
    output logic       LOCKED,
    output logic       FAULT,
    output logic [1:0] RETRY_CNT
);

    localparam int unsigned TW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

    sup_state_t    state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [1:0]    retry_nx;
    logic          sel_nx;
    logic          lock_s;

    lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clk      (CLKI),
        .rst      (RST),
        .async_in (PLL_LOCK),
        .sync_out (lock_s)
    );

    // Outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge CLKI) begin
        if (RST) begin
            state     <= ST_RESET;
            timer     <= '0;
            PLL_RST   <= 1'b1;
            PLL_SEL   <= 1'b0;
            SYS_RST   <= 1'b1;
            LOCKED    <= 1'b0;
            FAULT     <= 1'b0;
            RETRY_CNT <= '0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            PLL_SEL   <= sel_nx;
            RETRY_CNT <= retry_nx;
            PLL_RST   <= (state_nx == ST_RESET) || (state_nx == ST_RETRY) ||
                         (state_nx == ST_FAULT);
            SYS_RST   <= (state_nx != ST_RUN);
            LOCKED    <= (state_nx == ST_RUN);
            FAULT     <= (state_nx == ST_FAULT);
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        sel_nx   = PLL_SEL;
        retry_nx = RETRY_CNT;
        case (state)
            ST_RESET: begin
                if (timer == TW'(RST_CYCLES - 1)) begin
                    state_nx = ST_WAIT;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            ST_WAIT: begin
                if (lock_s) begin
                    state_nx = ST_STABLE;
                    timer_nx = '0;
                end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                    state_nx = ST_RETRY;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nx = ST_RETRY;
                    timer_nx = '0;
                end else if (timer == TW'(STABLE_CYCLES - 1)) begin
                    state_nx = ST_RUN;
                    timer_nx = '0;
                    retry_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nx = ST_RESET;
                    timer_nx = '0;
                end
            end
            ST_RETRY: begin
                // PLL_RST is high here, so PLL_SEL may switch without glitching the PLL.
                timer_nx = '0;
                if ({30'd0, RETRY_CNT} + 32'd1 < MAX_RETRIES) begin
                    retry_nx = RETRY_CNT + 2'd1;
                    state_nx = ST_RESET;
                end else if (ALT_REF_EN && !PLL_SEL) begin
                    sel_nx   = 1'b1;
                    retry_nx = '0;
                    state_nx = ST_RESET;
                end else begin
                    state_nx = ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_nx = ST_FAULT;
            end
            default: begin
                state_nx = ST_RESET;
                timer_nx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: an attempt-level model predicts every output change of two
// supervisor instances (with and without reference fail-over).
module tb_pll_lock_supervisor;

    localparam int RC   = 4;
    localparam int TO   = 20;
    localparam int SC   = 8;
    localparam int MR   = 2;
    localparam int NCYC = 400;
    // {PLL_RST, PLL_SEL, SYS_RST, LOCKED, FAULT, RETRY_CNT[1:0]}
    localparam logic [6:0] RST_VEC = 7'b1010000;

    logic CLKI = 1'b0;
    logic RST = 1'b1;
    logic PLL_LOCK = 1'b0;

    logic       a_pll_rst, a_pll_sel, a_sys_rst, a_locked, a_fault;
    logic [1:0] a_retry;
    logic       n_pll_rst, n_pll_sel, n_sys_rst, n_locked, n_fault;
    logic [1:0] n_retry;
    logic [6:0] out_alt, out_noalt;

    pll_lock_supervisor #(
        .RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC),
        .MAX_RETRIES(MR), .ALT_REF_EN(1'b1), .SYNC_STAGES(2)
    ) dut_alt (
        .CLKI(CLKI), .RST(RST), .PLL_LOCK(PLL_LOCK),
        .PLL_RST(a_pll_rst), .PLL_SEL(a_pll_sel), .SYS_RST(a_sys_rst),
        .LOCKED(a_locked), .FAULT(a_fault), .RETRY_CNT(a_retry)
    );

    pll_lock_supervisor #(
        .RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC),
        .MAX_RETRIES(MR), .ALT_REF_EN(1'b0), .SYNC_STAGES(2)
    ) dut_noalt (
        .CLKI(CLKI), .RST(RST), .PLL_LOCK(PLL_LOCK),
        .PLL_RST(n_pll_rst), .PLL_SEL(n_pll_sel), .SYS_RST(n_sys_rst),
        .LOCKED(n_locked), .FAULT(n_fault), .RETRY_CNT(n_retry)
    );

    assign out_alt   = {a_pll_rst, a_pll_sel, a_sys_rst, a_locked, a_fault, a_retry};
    assign out_noalt = {n_pll_rst, n_pll_sel, n_sys_rst, n_locked, n_fault, n_retry};

    always #5 CLKI = ~CLKI;

    typedef struct {
        int         cyc;
        logic [6:0] val;
    } ev_t;

    ev_t        q_alt[$];
    ev_t        q_noalt[$];
    logic       lk[NCYC];
    logic [6:0] expv[NCYC];
    int         checks = 0;
    int         failures = 0;
    int         cur_cyc = 0;
    bit         active = 1'b0;
    bit         req_rst_chk = 1'b0;
    bit         req_end_chk = 1'b0;
    logic [6:0] prev_alt, prev_noalt;

    // ---------------- reference model ----------------
    function automatic bit lock_s_at(input int start, input int c);
        if (c - start < 2 || c - 2 >= NCYC) return 1'b0;
        return lk[c-2];
    endfunction

    function automatic void fill(input int from, input int to, input int stop,
                                 input logic [6:0] v);
        for (int c = from; c < to && c < stop; c++) expv[c] = v;
    endfunction

    function automatic logic [6:0] vec(input bit prst, input bit sel, input bit srst,
                                       input bit lkd, input bit flt, input int cnt);
        return {prst, sel, srst, lkd, flt, 2'(cnt)};
    endfunction

    // Walks whole attempts: reset pulse, lock search window, stability window, run.
    function automatic void model_seg(input int start, input int stop, input bit alt);
        int t, retries, k, drop, r, j;
        bit sel, found;
        t = start; retries = 0; sel = 1'b0;
        while (t < stop) begin
            fill(t, t + RC, stop, vec(1, sel, 1, 0, 0, retries));
            t += RC;
            found = 1'b0; k = t;
            for (int c = t; c < t + TO; c++)
                if (!found && lock_s_at(start, c)) begin found = 1'b1; k = c; end
            if (!found) begin
                fill(t, t + TO, stop, vec(0, sel, 1, 0, 0, retries));
                t += TO;
            end else begin
                fill(t, k + 1, stop, vec(0, sel, 1, 0, 0, retries));
                drop = -1;
                for (int c = k + 1; c < k + 1 + SC; c++)
                    if (drop < 0 && !lock_s_at(start, c)) drop = c;
                if (drop >= 0) begin
                    fill(k + 1, drop + 1, stop, vec(0, sel, 1, 0, 0, retries));
                    t = drop + 1;
                end else begin
                    fill(k + 1, k + 1 + SC, stop, vec(0, sel, 1, 0, 0, retries));
                    r = k + 1 + SC;
                    retries = 0;
                    j = r;
                    while (j < stop && lock_s_at(start, j)) j++;
                    fill(r, j + 1, stop, vec(0, sel, 0, 1, 0, 0));
                    t = j + 1;
                    continue;
                end
            end
            fill(t, t + 1, stop, vec(1, sel, 1, 0, 0, retries));
            t++;
            if (retries + 1 < MR) retries++;
            else if (alt && !sel) begin sel = 1'b1; retries = 0; end
            else begin
                fill(t, stop, stop, vec(1, sel, 1, 0, 1, retries));
                t = stop;
            end
        end
    endfunction

    task automatic build(input bit alt, input int rst_cycle);
        logic [6:0] prev;
        ev_t e;
        if (rst_cycle >= 0) begin
            model_seg(0, rst_cycle + 1, alt);
            model_seg(rst_cycle + 1, NCYC, alt);
        end else begin
            model_seg(0, NCYC, alt);
        end
        prev = RST_VEC;
        for (int c = 0; c < NCYC; c++) begin
            if (expv[c] !== prev) begin
                e.cyc = c; e.val = expv[c];
                if (alt) q_alt.push_back(e); else q_noalt.push_back(e);
            end
            prev = expv[c];
        end
    endtask

    // ---------------- monitor ----------------
    task automatic pop_check(input bit alt, input logic [6:0] v, input int cyc);
        ev_t e;
        bit have;
        checks++;
        have = 1'b0;
        if (alt && q_alt.size() > 0) begin e = q_alt.pop_front(); have = 1'b1; end
        if (!alt && q_noalt.size() > 0) begin e = q_noalt.pop_front(); have = 1'b1; end
        if (!have) begin
            failures++;
            $display("FAIL out_change alt=%0d cyc=%0d got=%b required=no_change", alt, cyc, v);
        end else if (e.cyc != cyc || e.val !== v) begin
            failures++;
            $display("FAIL out_change alt=%0d got cyc=%0d val=%b required cyc=%0d val=%b",
                     alt, cyc, v, e.cyc, e.val);
        end
    endtask

    always @(negedge CLKI) begin
        #1;
        if (req_rst_chk) begin
            checks += 2;
            if (out_alt !== RST_VEC) begin
                failures++;
                $display("FAIL reset_vals alt=1 got=%b required=%b", out_alt, RST_VEC);
            end
            if (out_noalt !== RST_VEC) begin
                failures++;
                $display("FAIL reset_vals alt=0 got=%b required=%b", out_noalt, RST_VEC);
            end
        end
        if (req_end_chk) begin
            checks += 2;
            if (q_alt.size() != 0) begin
                failures++;
                $display("FAIL missing_change alt=1 got=none required cyc=%0d val=%b",
                         q_alt[0].cyc, q_alt[0].val);
            end
            if (q_noalt.size() != 0) begin
                failures++;
                $display("FAIL missing_change alt=0 got=none required cyc=%0d val=%b",
                         q_noalt[0].cyc, q_noalt[0].val);
            end
            q_alt.delete();
            q_noalt.delete();
        end
        if (!active) begin
            prev_alt   = RST_VEC;
            prev_noalt = RST_VEC;
        end else begin
            if (out_alt !== prev_alt) begin
                pop_check(1'b1, out_alt, cur_cyc);
                prev_alt = out_alt;
            end
            if (out_noalt !== prev_noalt) begin
                pop_check(1'b0, out_noalt, cur_cyc);
                prev_noalt = out_noalt;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_lock(input int from, input int to, input logic v);
        for (int c = from; c < to && c < NCYC; c++) lk[c] = v;
    endtask

    task automatic gen_random();
        int  c, len;
        bit  lv;
        c = 0; lv = 1'b0;
        while (c < NCYC) begin
            if (!lv) len = int'($urandom_range(45, 0));
            else if ($urandom_range(3, 0) == 0) len = int'($urandom_range(6, 1));
            else len = int'($urandom_range(150, 10));
            set_lock(c, c + len, lv);
            c += len;
            lv = !lv;
        end
    endtask

    task automatic run_scen(input int rst_cycle);
        build(1'b1, rst_cycle);
        build(1'b0, rst_cycle);
        RST = 1'b1;
        repeat (3) @(negedge CLKI);
        req_rst_chk = 1'b1;
        @(negedge CLKI);
        req_rst_chk = 1'b0;
        for (int k = 0; k < NCYC; k++) begin
            RST = (k == rst_cycle);
            PLL_LOCK = lk[k];
            cur_cyc = k;
            active = 1'b1;
            @(negedge CLKI);
        end
        active = 1'b0;
        RST = 1'b1;
        req_end_chk = 1'b1;
        @(negedge CLKI);
        req_end_chk = 1'b0;
    endtask

    initial begin
        // clean lock from cycle 10
        set_lock(0, NCYC, 1'b0); set_lock(10, NCYC, 1'b1);
        run_scen(-1);
        // lock never arrives: fail-over then fault (alt) / fault after ref0 (noalt)
        set_lock(0, NCYC, 1'b0);
        run_scen(-1);
        // one-cycle lock loss while running
        set_lock(0, NCYC, 1'b0); set_lock(10, NCYC, 1'b1); lk[60] = 1'b0;
        run_scen(-1);
        // glitch seen in STABLE at count 5
        set_lock(0, NCYC, 1'b0); set_lock(10, NCYC, 1'b1); lk[16] = 1'b0;
        run_scen(-1);
        // RST pulse while in RUN
        set_lock(0, NCYC, 1'b0); set_lock(10, NCYC, 1'b1);
        run_scen(100);
        // RST pulse while in FAULT, then lock after recovery
        set_lock(0, NCYC, 1'b0); set_lock(250, NCYC, 1'b1);
        run_scen(200);
        for (int s = 0; s < 12; s++) begin
            gen_random();
            if ($urandom_range(2, 0) == 0) run_scen(int'($urandom_range(370, 30)));
            else run_scen(-1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
